// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit holding HI/LO, with multi-cycle mult/div and a stall request.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        MDUing,
    output logic        Busy,
    output logic [31:0] MD_Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        start, is_mult;
    logic [63:0] sprod, uprod, res;
    logic [31:0] ua, ub, uq, ur, sq, sr;

    assign start   = reset && E_MDUOp >= 4'd1 && E_MDUOp <= 4'd4 && !busy_q;
    assign is_mult = E_MDUOp == 4'd1 || E_MDUOp == 4'd2;
    assign sprod   = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign uprod   = {32'b0, E_A} * {32'b0, E_B};
    // Signed division via magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0.
    assign ua = E_A[31] ? -E_A : E_A;
    assign ub = E_B[31] ? -E_B : E_B;
    assign uq = E_B == 32'd0 ? 32'd0 : E_A / E_B;
    assign ur = E_B == 32'd0 ? 32'd0 : E_A % E_B;
    assign sq = ub == 32'd0 ? 32'd0 : ((E_A[31] ^ E_B[31]) ? -(ua / ub) : ua / ub);
    assign sr = ub == 32'd0 ? 32'd0 : (E_A[31] ? -(ua % ub) : ua % ub);
    assign res = E_MDUOp == 4'd1 ? sprod :
                 E_MDUOp == 4'd2 ? uprod :
                 E_B == 32'd0    ? {hi_q, lo_q} :
                 E_MDUOp == 4'd3 ? {sr, sq} : {ur, uq};

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            {phi_d, plo_d} = res;
            cnt_d          = is_mult ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
            busy_d         = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                hi_d   = phi_q;
                lo_d   = plo_q;
                busy_d = 1'b0;
            end
        end else begin
            hi_d = E_MDUOp == 4'd7 ? E_A : hi_q;
            lo_d = E_MDUOp == 4'd8 ? E_A : lo_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            phi_q  <= '0;
            plo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign MDUing = start | busy_q;
    assign Busy   = busy_q;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MD_Out = E_MDUOp == 4'd5 ? hi_q : E_MDUOp == 4'd6 ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors with hand-computed results for mdu_unit.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic [31:0] E_A, E_B;
    logic        MDUing, Busy;
    logic [31:0] MD_Out, HI, LO;
    int          n_tests = 0;
    int          n_fail  = 0;

    mdu_unit dut (
        .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_A(E_A), .E_B(E_B),
        .MDUing(MDUing), .Busy(Busy), .MD_Out(MD_Out), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents op for one cycle, then idles; checks stall timing through to the commit cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int cycles);
        E_MDUOp = op;
        E_A     = a;
        E_B     = b;
        #1;
        check({tag, " start mduing"}, 32'(MDUing), 32'd1);
        check({tag, " start busy"}, 32'(Busy), 32'd0);
        tick();
        E_MDUOp = 4'd0;
        repeat (cycles - 1) tick();
        check({tag, " last busy"}, 32'(Busy), 32'd1);
        check({tag, " last mduing"}, 32'(MDUing), 32'd1);
        tick();
        check({tag, " done busy"}, 32'(Busy), 32'd0);
        check({tag, " done mduing"}, 32'(MDUing), 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        E_MDUOp = 4'd1;
        E_A     = 32'd3;
        E_B     = 32'd4;
        tick();
        tick();
        check("rst hi", HI, 32'd0);
        check("rst lo", LO, 32'd0);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst mduing", 32'(MDUing), 32'd0);
        E_MDUOp = 4'd0;
        reset   = 1'b1;
        tick();

        E_MDUOp = 4'd1;
        E_A     = 32'd3;
        E_B     = 32'hFFFFFFFE;
        #1;
        check("mult t mduing", 32'(MDUing), 32'd1);
        check("mult t busy", 32'(Busy), 32'd0);
        tick();
        E_MDUOp = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            check("mult busy", 32'(Busy), 32'd1);
            check("mult mduing", 32'(MDUing), 32'd1);
            check("mult hi hidden", HI, 32'd0);
            tick();
        end
        check("mult t6 mduing", 32'(MDUing), 32'd0);
        check("mult t6 busy", 32'(Busy), 32'd0);
        check("mult hi", HI, 32'hFFFFFFFF);
        check("mult lo", LO, 32'hFFFFFFFA);

        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
        check("multu hi", HI, 32'hFFFFFFFE);
        check("multu lo", LO, 32'h00000001);

        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
        check("div lo", LO, 32'hFFFFFFFD);
        check("div hi", HI, 32'hFFFFFFFF);

        run_op("div neg divisor", 4'd3, 32'd7, 32'hFFFFFFFE, 10);
        check("div2 lo", LO, 32'hFFFFFFFD);
        check("div2 hi", HI, 32'd1);

        run_op("divu", 4'd4, 32'd100, 32'd7, 10);
        check("divu lo", LO, 32'd14);
        check("divu hi", HI, 32'd2);

        run_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        check("ovf lo", LO, 32'h80000000);
        check("ovf hi", HI, 32'd0);

        E_MDUOp = 4'd7;
        E_A     = 32'h1234;
        #1;
        check("mthi mduing", 32'(MDUing), 32'd0);
        tick();
        E_MDUOp = 4'd8;
        E_A     = 32'd0;
        tick();
        check("mthi hi", HI, 32'h1234);
        check("mtlo lo", LO, 32'd0);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 10);
        check("div0 hi", HI, 32'h1234);
        check("div0 lo", LO, 32'd0);

        E_MDUOp = 4'd12;
        E_A     = 32'hDEAD;
        #1;
        check("op12 mduing", 32'(MDUing), 32'd0);
        check("op12 mdout", MD_Out, 32'd0);
        tick();
        check("op12 hi", HI, 32'h1234);
        check("op12 busy", 32'(Busy), 32'd0);

        E_MDUOp = 4'd1;
        E_A     = 32'd2;
        E_B     = 32'd3;
        tick();
        E_MDUOp = 4'd0;
        tick();
        reset = 1'b0;
        #1;
        check("midrst busy", 32'(Busy), 32'd0);
        check("midrst mduing", 32'(MDUing), 32'd0);
        check("midrst hi", HI, 32'd0);
        check("midrst lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        repeat (8) tick();
        check("no commit hi", HI, 32'd0);
        check("no commit lo", LO, 32'd0);
        check("no commit busy", 32'(Busy), 32'd0);

        E_MDUOp = 4'd8;
        E_A     = 32'd5;
        tick();
        E_MDUOp = 4'd6;
        #1;
        check("mflo", MD_Out, 32'd5);
        E_MDUOp = 4'd5;
        #1;
        check("mfhi", MD_Out, 32'd0);
        E_MDUOp = 4'd1;
        E_A     = 32'd4;
        E_B     = 32'd5;
        tick();
        for (int i = 1; i <= 4; i++) begin
            E_MDUOp = (i % 2 == 1) ? 4'd8 : 4'd7;
            E_A     = 32'd9;
            tick();
            check("busy mt lo", LO, 32'd5);
            check("busy mt hi", HI, 32'd0);
        end
        E_MDUOp = 4'd6;
        #1;
        check("busy mflo", MD_Out, 32'd5);
        tick();
        E_MDUOp = 4'd0;
        check("busy commit lo", LO, 32'd20);
        check("busy commit hi", HI, 32'd0);
        check("busy commit busy", 32'(Busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
